// File: rtl/pipeline_selftest_sequencer.sv
// Self-test sequencer: streams stored vectors into the permutation pipeline and checks
// each returned result in order, with optional input gaps and result backpressure.
module pipeline_selftest_sequencer #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned BOT_WIDTH   = 128,
  parameter int unsigned SUM_WIDTH   = 48,
  parameter int unsigned COUNT_WIDTH = 13,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned READY_HIGH  = 32,
  parameter int unsigned READY_LOW   = 32,
  parameter int unsigned TIMEOUT     = 4096,
  localparam int unsigned IW         = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 vecWrite,
  input  logic [IW-1:0]        vecAddr,
  input  logic [BOT_WIDTH+64:0] vecData,
  input  logic                 start,
  input  logic [IW:0]          numVectors,
  input  logic [1:0]           mode,
  output logic                 dutValid,
  input  logic                 dutReady,
  output logic                 startNewTop,
  output logic [BOT_WIDTH-1:0] bot,
  input  logic                 dutResultValid,
  output logic                 dutResultReady,
  input  logic [63:0]          dutResult,
  output logic                 busy,
  output logic                 done,
  output logic                 timedOut,
  output logic                 spurious,
  output logic [IW:0]          passCount,
  output logic [IW:0]          errorCount,
  output logic [IW:0]          eccCount,
  output logic [IW-1:0]        firstErrorIndex
);

  localparam int unsigned VW   = BOT_WIDTH + 65;
  localparam int unsigned CMPW = SUM_WIDTH + COUNT_WIDTH;
  localparam int unsigned BW   = $clog2(BURST_LEN + 1);
  localparam int unsigned GW   = $clog2(GAP_CYCLES + 1);
  localparam int unsigned RW   = $clog2(READY_HIGH + READY_LOW);
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW:0]     issue_q, issue_d, recv_q, recv_d, num_q, num_d;
  logic [IW:0]     pass_q, pass_d, err_q, err_d, ecc_q, ecc_d;
  logic [IW-1:0]   first_q, first_d;
  logic [1:0]      mode_q, mode_d;
  logic [TW-1:0]   to_q, to_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [RW-1:0]   rdy_q, rdy_d;
  logic            timed_out_q, timed_out_d, spurious_q, spurious_d;

  logic [VW-1:0]   mem [DEPTH];
  logic [VW-1:0]   issue_word, recv_word;
  logic            dut_valid, in_hs, res_hs, num_ok, result_match;

  function automatic logic [IW:0] sat_inc(input logic [IW:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Contents survive reset so a run can be repeated after an abort.
  always_ff @(posedge clock) begin
    if (vecWrite && !busy) mem[vecAddr] <= vecData;
  end

  assign issue_word   = mem[issue_q[IW-1:0]];
  assign recv_word    = mem[recv_q[IW-1:0]];
  assign busy         = (state_q == StRun) || (state_q == StDrain);
  assign done         = (state_q == StDone);
  assign dut_valid    = (state_q == StRun) && (gap_q == '0);
  assign in_hs        = dut_valid && dutReady;
  assign res_hs       = dutResultValid && dutResultReady;
  assign num_ok       = (numVectors != '0) && (numVectors <= (IW+1)'(DEPTH));
  assign result_match = (dutResult[CMPW-1:0] == recv_word[CMPW-1:0]);

  assign dutValid        = dut_valid;
  assign startNewTop     = dut_valid & issue_word[VW-1];
  assign bot             = dut_valid ? issue_word[VW-2:64] : '0;
  assign dutResultReady  = busy && (!mode_q[1] || (rdy_q < RW'(READY_HIGH)));
  assign timedOut        = timed_out_q;
  assign spurious        = spurious_q;
  assign passCount       = pass_q;
  assign errorCount      = err_q;
  assign eccCount        = ecc_q;
  assign firstErrorIndex = first_q;

  logic unused_bits;
  assign unused_bits = ^{issue_word[63:0], recv_word[VW-1:CMPW], dutResult[62:CMPW]};

  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    recv_d      = recv_q;
    num_d       = num_q;
    mode_d      = mode_q;
    pass_d      = pass_q;
    err_d       = err_q;
    ecc_d       = ecc_q;
    first_d     = first_q;
    to_d        = to_q;
    burst_d     = burst_q;
    gap_d       = gap_q;
    rdy_d       = rdy_q;
    timed_out_d = timed_out_q;
    spurious_d  = spurious_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start && num_ok) begin
          state_d     = StRun;
          issue_d     = '0;
          recv_d      = '0;
          num_d       = numVectors;
          mode_d      = mode;
          pass_d      = '0;
          err_d       = '0;
          ecc_d       = '0;
          first_d     = '0;
          to_d        = '0;
          burst_d     = '0;
          gap_d       = '0;
          rdy_d       = '0;
          timed_out_d = 1'b0;
          spurious_d  = 1'b0;
        end
      end
      StRun, StDrain: begin
        if (in_hs) begin
          issue_d = issue_q + 1'b1;
          if (mode_q[0]) begin
            if (burst_q == BW'(BURST_LEN - 1)) begin
              burst_d = '0;
              gap_d   = GW'(GAP_CYCLES);
            end else begin
              burst_d = burst_q + 1'b1;
            end
          end
        end else if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end

        // Ready duty pattern runs free of the input side.
        rdy_d = (rdy_q == RW'(READY_HIGH + READY_LOW - 1)) ? '0 : rdy_q + 1'b1;

        if (res_hs) begin
          to_d = '0;
          if (recv_q < issue_q) begin
            recv_d = recv_q + 1'b1;
            if (result_match) begin
              pass_d = sat_inc(pass_q);
            end else begin
              err_d = sat_inc(err_q);
              if (err_q == '0) first_d = recv_q[IW-1:0];
            end
            if (dutResult[63]) ecc_d = sat_inc(ecc_q);
          end else begin
            spurious_d = 1'b1;
          end
        end else if (recv_q < issue_q) begin
          to_d = to_q + 1'b1;
        end

        if ((state_q == StRun) && (issue_d == num_q)) state_d = StDrain;
        if ((state_q == StDrain) && (recv_d == num_q)) state_d = StDone;
        if (to_d == TW'(TIMEOUT)) begin
          timed_out_d = 1'b1;
          state_d     = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q     <= StIdle;
      issue_q     <= '0;
      recv_q      <= '0;
      num_q       <= '0;
      mode_q      <= '0;
      pass_q      <= '0;
      err_q       <= '0;
      ecc_q       <= '0;
      first_q     <= '0;
      to_q        <= '0;
      burst_q     <= '0;
      gap_q       <= '0;
      rdy_q       <= '0;
      timed_out_q <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      recv_q      <= recv_d;
      num_q       <= num_d;
      mode_q      <= mode_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      ecc_q       <= ecc_d;
      first_q     <= first_d;
      to_q        <= to_d;
      burst_q     <= burst_d;
      gap_q       <= gap_d;
      rdy_q       <= rdy_d;
      timed_out_q <= timed_out_d;
      spurious_q  <= spurious_d;
    end
  end

endmodule

// File: tb/tb_pipeline_selftest_sequencer.sv
// Bench for pipeline_selftest_sequencer: a queue-based pipeline model with random latency
// feeds results back; expected counts come from comparing results to the loaded vectors.
module tb_pipeline_selftest_sequencer;

  localparam int DEPTH     = 256;
  localparam int IW        = 8;
  localparam int BOTW      = 128;
  localparam int BURST     = 16;
  localparam int GAP       = 8;
  localparam int RHIGH     = 32;
  localparam int RPERIOD   = 64;
  localparam int TIMEOUT   = 4096;
  localparam int NO_DROP   = DEPTH + 1;

  logic            clock = 1'b0;
  logic            rst;
  logic            vecWrite;
  logic [IW-1:0]   vecAddr;
  logic [BOTW+64:0] vecData;
  logic            start;
  logic [IW:0]     numVectors;
  logic [1:0]      mode;
  logic            dutValid, dutReady, startNewTop;
  logic [BOTW-1:0] bot;
  logic            dutResultValid, dutResultReady;
  logic [63:0]     dutResult;
  logic            busy, done, timedOut, spurious;
  logic [IW:0]     passCount, errorCount, eccCount;
  logic [IW-1:0]   firstErrorIndex;

  pipeline_selftest_sequencer dut (
    .clock          (clock),
    .rst            (rst),
    .vecWrite       (vecWrite),
    .vecAddr        (vecAddr),
    .vecData        (vecData),
    .start          (start),
    .numVectors     (numVectors),
    .mode           (mode),
    .dutValid       (dutValid),
    .dutReady       (dutReady),
    .startNewTop    (startNewTop),
    .bot            (bot),
    .dutResultValid (dutResultValid),
    .dutResultReady (dutResultReady),
    .dutResult      (dutResult),
    .busy           (busy),
    .done           (done),
    .timedOut       (timedOut),
    .spurious       (spurious),
    .passCount      (passCount),
    .errorCount     (errorCount),
    .eccCount       (eccCount),
    .firstErrorIndex(firstErrorIndex)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic            sntv   [DEPTH];
  logic [BOTW-1:0] botv   [DEPTH];
  logic [63:0]     expv   [DEPTH];  // what the pipeline really produces
  logic [63:0]     memexp [DEPTH];  // expected field as stored in the sequencer

  typedef struct {
    int          idx;
    int          rdy_at;
    logic [63:0] res;
  } ent_t;
  ent_t pipe[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] make_res(input int i);
    logic [63:0] r;
    r        = expv[i];
    r[62:61] = 2'($urandom_range(0, 3));
    r[63]    = ($urandom_range(0, 3) == 0);
    return r;
  endfunction

  task automatic write_vec(input int i);
    vecWrite = 1'b1;
    vecAddr  = IW'(i);
    vecData  = {sntv[i], botv[i], memexp[i]};
    tick();
    vecWrite = 1'b0;
  endtask

  task automatic run_seq(input string name, input int num, input logic [1:0] md,
                         input int drop_from, input bit spur, input bit exp_to);
    int acc = 0, recv = 0, t = 0, gap_left = 0, last_hs = 0;
    int e_pass = 0, e_err = 0, e_ecc = 0, e_first = 0;
    int budget;
    bit finished = 0, prev_stall = 0, rdy;
    logic exp_valid, exp_rdy;
    logic            prev_snt;
    logic [BOTW-1:0] prev_bot;
    ent_t e;
    budget = exp_to ? 6000 : 3000;
    pipe.delete();
    dutResultValid = 1'b0;
    numVectors = (IW+1)'(num);
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_start_busy"}, {busy, done}, 2'b10);

    for (int cyc = 0; cyc < budget; cyc++) begin
      if (!exp_to && recv == num) begin
        chk({name, "_done_after_last"}, {done, busy}, 2'b10);
        finished = 1;
        break;
      end
      if (exp_to && timedOut === 1'b1) begin
        chk({name, "_timeout_delay"}, cyc - last_hs, TIMEOUT + 1);
        finished = 1;
        break;
      end
      if (spur && cyc == 1) begin
        chk({name, "_spurious_flag"}, {spurious, passCount, errorCount, eccCount}, {1'b1, 27'd0});
      end

      exp_valid = (acc < num) && (gap_left == 0);
      chk({name, "_dut_valid"}, dutValid, exp_valid);
      if (gap_left > 0) gap_left--;
      exp_rdy = md[1] ? ((t % RPERIOD) < RHIGH) : 1'b1;
      chk({name, "_res_ready"}, dutResultReady, exp_rdy);
      t++;
      if (prev_stall) begin
        chk({name, "_stable"}, {dutValid, startNewTop, bot}, {1'b1, prev_snt, prev_bot});
      end

      rdy = md[1] ? ($urandom_range(0, 3) != 0) : 1'b1;
      dutReady = rdy;
      if (dutValid && rdy) begin
        chk({name, "_vec_data"}, {startNewTop, bot}, {sntv[acc], botv[acc]});
        if (acc < drop_from) begin
          e.idx = acc;
          e.rdy_at = cyc + int'($urandom_range(1, 4));
          e.res = make_res(acc);
          pipe.push_back(e);
        end
        acc++;
        if (md[0] && (acc % BURST == 0)) gap_left = GAP;
      end
      prev_stall = dutValid && !rdy;
      prev_snt   = startNewTop;
      prev_bot   = bot;

      if (spur && cyc == 0) begin
        dutResultValid = 1'b1;
        dutResult      = {$urandom, $urandom};
      end else if (pipe.size() > 0 && pipe[0].rdy_at <= cyc) begin
        dutResultValid = 1'b1;
        dutResult      = pipe[0].res;
        if (dutResultReady) begin
          e = pipe.pop_front();
          if (e.res[60:0] == memexp[recv][60:0]) e_pass++;
          else begin
            if (e_err == 0) e_first = recv;
            e_err++;
          end
          if (e.res[63]) e_ecc++;
          recv++;
          last_hs = cyc;
        end
      end else begin
        dutResultValid = 1'b0;
        dutResult      = '0;
      end
      tick();
    end

    dutResultValid = 1'b0;
    chk({name, "_finished_in_budget"}, finished, 1'b1);
    chk({name, "_pass"}, passCount, e_pass);
    chk({name, "_err"}, errorCount, e_err);
    chk({name, "_ecc"}, eccCount, e_ecc);
    if (e_err > 0) chk({name, "_first_err"}, firstErrorIndex, e_first);
    chk({name, "_flags"}, {done, busy, timedOut, spurious, dutResultReady},
        {1'b1, 1'b0, exp_to, spur, 1'b0});
  endtask

  initial begin
    rst = 1'b0;
    vecWrite = 1'b0; vecAddr = '0; vecData = '0;
    start = 1'b0; numVectors = '0; mode = '0;
    dutReady = 1'b0; dutResultValid = 1'b0; dutResult = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sntv[i]   = 1'($urandom_range(0, 1));
      botv[i]   = {$urandom, $urandom, $urandom, $urandom};
      expv[i]   = {$urandom, $urandom};
      memexp[i] = expv[i];
    end
    repeat (3) tick();
    chk("reset_status", {busy, done, timedOut, spurious, dutValid, dutResultReady, startNewTop},
        7'd0);
    chk("reset_counts", {passCount, errorCount, eccCount, firstErrorIndex, bot}, '0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) write_vec(i);

    run_seq("basic", 200, 2'b00, NO_DROP, 1'b0, 1'b0);
    chk("basic_all_pass", {passCount, errorCount}, {9'd200, 9'd0});

    // Illegal vector counts leave the sequencer in DONE.
    numVectors = '0; start = 1'b1; tick(); start = 1'b0;
    chk("start_num0_ignored", {busy, done}, 2'b01);
    numVectors = 9'd257; start = 1'b1; tick(); start = 1'b0;
    chk("start_num257_ignored", {busy, done}, 2'b01);

    memexp[37][0] = ~memexp[37][0];
    write_vec(37);
    run_seq("corrupt37", 200, 2'b00, NO_DROP, 1'b0, 1'b0);
    chk("corrupt37_counts", {passCount, errorCount, firstErrorIndex}, {9'd199, 9'd1, 8'd37});
    memexp[37] = expv[37];
    write_vec(37);

    run_seq("mode3", 200, 2'b11, NO_DROP, 1'b0, 1'b0);

    run_seq("drop5", 20, 2'b00, 5, 1'b0, 1'b1);
    chk("drop5_stalled", passCount, 9'd5);

    run_seq("spur", 20, 2'b00, NO_DROP, 1'b1, 1'b0);

    numVectors = 9'd200; mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0; dutReady = 1'b1;
    repeat (10) tick();
    rst = 1'b0;
    tick();
    chk("midrun_reset", {busy, done, dutValid, dutResultReady, startNewTop, bot, passCount},
        '0);
    rst = 1'b1;
    dutReady = 1'b0;
    tick();
    run_seq("restart", 200, 2'b00, NO_DROP, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_selftest_sequencer.md
# pipeline_selftest_sequencer

Synthesizable on-chip self-test sequencer for the full permutation pipeline. It holds up to DEPTH test vectors, each being startNewTop, a 128-bit bot and a 64-bit expected result. It streams the vectors into the pipeline over a valid/ready handshake and checks every returned result in order, keeping pass, error and ECC counts. Selectable modes inject input gaps and output backpressure, so the pipeline's flow control is exercised in hardware.

## Interface
- DEPTH, 256, vector memory entries; IW = $clog2(DEPTH)
- BOT_WIDTH, 128, bot width
- SUM_WIDTH, 48, summed-data field, result[SUM_WIDTH-1:0]
- COUNT_WIDTH, 13, pcoeff count field, result[SUM_WIDTH+COUNT_WIDTH-1:SUM_WIDTH]
- BURST_LEN, 16, accepted inputs between gaps (mode bit 0)
- GAP_CYCLES, 8, length of each input gap
- READY_HIGH / READY_LOW, 32 / 32, resultReady duty pattern (mode bit 1)
- TIMEOUT, 4096, idle cycles with outstanding results before abort
- clock  in  1  clock
- rst  in  1  synchronous, active-low reset
- vecWrite  in  1  memory write strobe; honoured only in IDLE/DONE
- vecAddr  in  IW  write address
- vecData  in  1+BOT_WIDTH+64  {startNewTop, bot, expected}
- start  in  1  begin run; honoured only in IDLE/DONE
- numVectors  in  IW+1  vectors per run, sampled on start; 0 or >DEPTH is ignored
- mode  in  2  bit0 input gaps, bit1 output backpressure; sampled on start
- dutValid  out  1  vector valid toward pipeline
- dutReady  in  1  pipeline accepts input
- startNewTop  out  1  vector field
- bot  out  BOT_WIDTH  vector field
- dutResultValid  in  1  pipeline result valid
- dutResultReady  out  1  sequencer accepts result
- dutResult  in  64  bit 63 ECC status, count and sum fields as above
- busy, done, timedOut, spurious  out  1 each  status
- passCount, errorCount, eccCount  out  IW+1  counters
- firstErrorIndex  out  IW  index of first mismatch; valid when errorCount>0

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE: start with a legal numVectors clears counters and flags, latches mode, zeroes issueIdx/recvIdx, then enters RUN.
- RUN: dutValid=1 unless in a gap. Input handshake (dutValid&dutReady) increments issueIdx. When issueIdx reaches numVectors, go to DRAIN.
- DRAIN: dutValid=0. When recvIdx reaches numVectors, go to DONE.
- Vector memory has an asynchronous read. bot and startNewTop are taken from mem[issueIdx], and expected is taken from mem[recvIdx].
- Once dutValid is high, it and its data stay stable until the handshake.
- Result handshake (dutResultValid&dutResultReady), checked when recvIdx<issueIdx:
  - Compare the sum field and the count field against expected. Bits 62:COUNT_WIDTH+SUM_WIDTH are ignored.
  - Match increments passCount. Mismatch increments errorCount; on the first mismatch, record recvIdx in firstErrorIndex.
  - ECC bit 63 set increments eccCount independently of the comparison.
  - recvIdx increments.
- Result handshake with recvIdx==issueIdx (more outputs than inputs): sets sticky spurious; the result is discarded and no counters change.
- Mode bit0: after every BURST_LEN accepted inputs, dutValid is held low for GAP_CYCLES cycles.
- Mode bit1: dutResultReady follows READY_HIGH cycles high then READY_LOW cycles low, starting high on the first RUN cycle.
- Mode bit1 clear: dutResultReady=1 in RUN/DRAIN. In IDLE/DONE, dutResultReady=0.
- Timeout counter: clears on any result handshake or on entry to RUN. It increments while recvIdx<issueIdx. Reaching TIMEOUT sets timedOut and forces DONE.
- Counters saturate at 2^(IW+1)-1.

## Timing
- Reset: state IDLE; all outputs, counters and flags 0; memory contents retained. Reset mid-run aborts immediately.
- start registered in cycle N: RUN and dutValid=1 from cycle N+1.
- Counters and recvIdx update the cycle after the handshake.
- done=1 from the cycle after the last result handshake and holds until the next start. busy=1 exactly in RUN/DRAIN.
- Input and result handshakes in the same cycle are both processed.
- When the final input and a result coincide, RUN→DRAIN and the result check happen together.
- start while busy is ignored. vecWrite while busy is ignored.
- Gap counting continues across result backpressure; the gap counter is independent of the ready pattern.

## Test plan
- Load 200 vectors, mode 0, DUT always ready with results correct → done, passCount=200, errorCount=0, eccCount=0.
- Corrupt the expected sum of vector 37 → errorCount=1, firstErrorIndex=37, passCount=199.
- Mode 3, 200 vectors → dutValid low 8 cycles after every 16th acceptance; ready pattern 32/32 observed; all 200 pass; no data change while dutValid&!dutReady.
- DUT drops the output of vector 5 → timedOut=1 after 4096 idle cycles, done=1, recvIdx stalled.
- DUT emits an extra result after the final one → spurious=1, counters unchanged. Also: rst low mid-RUN → next cycle IDLE, all outputs 0; restart with memory intact passes.
